// File: rtl/instr_fetch_if.sv
// Bundled PC, byte-memory and decoded-instruction signals of the instr_fetch block.
// The slave modport is the fetch unit; the master modport is the surrounding environment.
interface instr_fetch_if #(
   parameter int ADDR_W = 64
);
   logic              pc_valid;
   logic [ADDR_W-1:0] pc_addr;
   logic              pc_ready;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rvalid;
   logic [7:0]        mem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [3:0]        icode;
   logic [3:0]        ifun;
   logic [3:0]        rA;
   logic [3:0]        rB;
   logic [63:0]       valC;
   logic [ADDR_W-1:0] valP;
   logic              instr_err;

   modport slave (
      input  pc_valid, pc_addr, mem_rvalid, mem_rdata, out_ready,
      output pc_ready, mem_req, mem_addr, out_valid,
      output icode, ifun, rA, rB, valC, valP, instr_err
   );

   modport master (
      output pc_valid, pc_addr, mem_rvalid, mem_rdata, out_ready,
      input  pc_ready, mem_req, mem_addr, out_valid,
      input  icode, ifun, rA, rB, valC, valP, instr_err
   );
endinterface

// File: rtl/instr_fetch.sv
// Y86-style instruction fetch: reads one byte per handshake and assembles the decoded fields.
// Optional INSTR_CHECK_EN flags icode values above 11 through instr_err.
module instr_fetch #(
   parameter int ADDR_W = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   instr_fetch_if.slave bus,
   output logic [1:0]  dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1
   // (pc: pc_valid/pc_ready, memory: mem_req/mem_rvalid, result: out_valid/out_ready);
   // the side raising valid holds it and its payload stable until the transfer.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] valp_q;
   logic [3:0]        idx_q;
   logic [3:0]        len_q;
   logic [3:0]        icode_q;
   logic [3:0]        ifun_q;
   logic [3:0]        ra_q;
   logic [3:0]        rb_q;
   logic [63:0]       valc_q;

   logic              xfer;
   logic [3:0]        len0;
   logic [3:0]        cur_len;
   logic              last_byte;

   function automatic logic [3:0] decode_len(input logic [3:0] ic);
      logic [3:0] len;
      case (ic)
         4'h0, 4'h1, 4'h9:        len = 4'd1;
         4'h2, 4'h6, 4'hA, 4'hB:  len = 4'd2;
         4'h3, 4'h4, 4'h5:        len = 4'd10;
         4'h7, 4'h8:              len = 4'd9;
         default:                 len = 4'd1;
      endcase
      return len;
   endfunction

   // Byte 0 decides the length in the same cycle it arrives, so a 1-byte instruction ends there.
   assign xfer      = (state_q == FETCH) && bus.mem_rvalid;
   assign len0      = decode_len(bus.mem_rdata[7:4]);
   assign cur_len   = (idx_q == 4'd0) ? len0 : len_q;
   assign last_byte = xfer && (idx_q == cur_len - 4'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.pc_valid)  state_d = FETCH;
         FETCH:   if (last_byte)     state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   assign dbg_state     = state_q;
   assign bus.pc_ready  = (state_q == IDLE);
   assign bus.mem_req   = (state_q == FETCH);
   assign bus.out_valid = (state_q == DONE);
   assign bus.mem_addr  = pc_q + ADDR_W'(idx_q);
   assign bus.icode     = icode_q;
   assign bus.ifun      = ifun_q;
   assign bus.rA        = ra_q;
   assign bus.rB        = rb_q;
   assign bus.valC      = valc_q;
   assign bus.valP      = valp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= '0;
         valp_q  <= '0;
         idx_q   <= 4'd0;
         len_q   <= 4'd1;
         icode_q <= 4'h0;
         ifun_q  <= 4'h0;
         ra_q    <= 4'hF;
         rb_q    <= 4'hF;
         valc_q  <= 64'd0;
      end else begin
         if ((state_q == IDLE) && bus.pc_valid) begin
            pc_q  <= bus.pc_addr;
            idx_q <= 4'd0;
         end
         if (xfer) begin
            idx_q <= idx_q + 4'd1;
            if (idx_q == 4'd0) begin
               icode_q <= bus.mem_rdata[7:4];
               ifun_q  <= bus.mem_rdata[3:0];
               len_q   <= len0;
               ra_q    <= 4'hF;
               rb_q    <= 4'hF;
               valc_q  <= 64'd0;
               valp_q  <= pc_q + ADDR_W'(len0);
            end else if (((len_q == 4'd2) || (len_q == 4'd10)) && (idx_q == 4'd1)) begin
               ra_q <= bus.mem_rdata[7:4];
               rb_q <= bus.mem_rdata[3:0];
            end else if ((len_q == 4'd9) || (len_q == 4'd10)) begin
               // Shifting in from the top leaves the lowest-address byte in valC[7:0] after 8 bytes.
               valc_q <= {bus.mem_rdata, valc_q[63:8]};
            end
         end
      end
   end

`ifdef INSTR_CHECK_EN
   logic err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        err_q <= 1'b0;
      else if (xfer && (idx_q == 4'd0))  err_q <= (bus.mem_rdata[7:4] > 4'd11);
   end

   assign bus.instr_err = err_q;
`else
   assign bus.instr_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed fetches plus randomized instructions,
// stalls and output back-pressure, compared against a byte-level reference model.
module tb_instr_fetch;
   localparam int ADDR_W = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

   instr_fetch #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  img[$];
   logic [63:0] exp_q[$];
   logic [63:0] e_icode, e_ifun, e_ra, e_rb, e_valc, e_valp, e_err, e_len;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int spec_len(input int ic);
      if (ic inside {0, 1, 9})        return 1;
      if (ic inside {2, 6, 10, 11})   return 2;
      if (ic inside {3, 4, 5})        return 10;
      if (ic inside {7, 8})           return 9;
      return 1;
   endfunction

   // Reference: derive every field straight from the instruction image.
   task automatic model_push(input logic [63:0] pc);
      logic [7:0]  b0, b1;
      logic [63:0] vc;
      int          len, ic, base;
      b0  = img[0];
      b1  = img[1];
      ic  = int'(b0[7:4]);
      len = spec_len(ic);
      vc  = 64'd0;
      base = (len == 10) ? 2 : 1;
      if (len >= 9)
         for (int i = 0; i < 8; i++) vc = vc | (64'(img[base + i]) << (8 * i));
      exp_q.push_back(64'(ic));
      exp_q.push_back(64'(b0[3:0]));
      exp_q.push_back((len == 2 || len == 10) ? 64'(b1[7:4]) : 64'hF);
      exp_q.push_back((len == 2 || len == 10) ? 64'(b1[3:0]) : 64'hF);
      exp_q.push_back(vc);
      exp_q.push_back(pc + 64'(len));
`ifdef INSTR_CHECK_EN
      exp_q.push_back((ic > 11) ? 64'd1 : 64'd0);
`else
      exp_q.push_back(64'd0);
`endif
      exp_q.push_back(64'(len));
   endtask

   task automatic check_fields(input string tag);
      check({tag, "_icode"}, 64'(bus.icode), e_icode);
      check({tag, "_ifun"},  64'(bus.ifun),  e_ifun);
      check({tag, "_rA"},    64'(bus.rA),    e_ra);
      check({tag, "_rB"},    64'(bus.rB),    e_rb);
      check({tag, "_valC"},  bus.valC,       e_valc);
      check({tag, "_valP"},  bus.valP,       e_valp);
      check({tag, "_err"},   64'(bus.instr_err), e_err);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_pc_ready"},  64'(bus.pc_ready),  64'd1);
      check({tag, "_mem_req"},   64'(bus.mem_req),   64'd0);
      check({tag, "_mem_addr"},  bus.mem_addr,       64'd0);
      check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_icode"},     64'(bus.icode),     64'd0);
      check({tag, "_ifun"},      64'(bus.ifun),      64'd0);
      check({tag, "_rA"},        64'(bus.rA),        64'hF);
      check({tag, "_rB"},        64'(bus.rB),        64'hF);
      check({tag, "_valC"},      bus.valC,           64'd0);
      check({tag, "_valP"},      bus.valP,           64'd0);
      check({tag, "_err"},       64'(bus.instr_err), 64'd0);
   endtask

   function automatic int pick_stall(input int mode);
      if (mode == 1) return int'($urandom_range(0, 2));
      if (mode == 2) return 3;
      return 0;
   endfunction

   // Runs one fetch of img at pc. stall_mode: 0 none, 1 random, 2 three-cycle stalls.
   // abort_after > 0 pulses reset once that many bytes have transferred.
   task automatic run_fetch(input logic [63:0] pc, input int stall_mode, input int hold,
                            input int abort_after);
      int edges, idx, stall_left;
      logic req_now, rv_now;
      model_push(pc);
      @(negedge clk);
      check("pc_ready_idle", 64'(bus.pc_ready), 64'd1);
      bus.pc_valid = 1'b1;
      bus.pc_addr  = pc;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      idx = 0;
      stall_left = pick_stall(stall_mode);
      while (!bus.out_valid && edges < 200) begin
         bus.pc_valid = 1'($urandom_range(0, 1));
         bus.pc_addr  = {$urandom, $urandom};
         req_now = bus.mem_req;
         if (req_now) begin
            check("mem_addr", bus.mem_addr, pc + 64'(idx));
            check("pc_ready_busy", 64'(bus.pc_ready), 64'd0);
            if (stall_left > 0) begin
               rv_now = 1'b0;
               stall_left--;
            end else begin
               rv_now = 1'b1;
            end
            bus.mem_rdata = (idx < img.size()) ? img[idx] : 8'(($urandom));
         end else begin
            rv_now = 1'($urandom_range(0, 1));
            bus.mem_rdata = 8'($urandom);
         end
         bus.mem_rvalid = rv_now;
         @(posedge clk);
         edges++;
         if (req_now && rv_now) begin
            idx++;
            stall_left = pick_stall(stall_mode);
         end
         if (abort_after > 0 && idx == abort_after) begin
            #2 rst_n = 1'b0;
            bus.pc_valid = 1'b0;
            bus.mem_rvalid = 1'b0;
            #1 check_reset("mid_reset");
            @(negedge clk);
            rst_n = 1'b1;
            exp_q.delete();
            return;
         end
         @(negedge clk);
      end
      bus.mem_rvalid = 1'($urandom_range(0, 1));
      e_icode = exp_q.pop_front();
      e_ifun  = exp_q.pop_front();
      e_ra    = exp_q.pop_front();
      e_rb    = exp_q.pop_front();
      e_valc  = exp_q.pop_front();
      e_valp  = exp_q.pop_front();
      e_err   = exp_q.pop_front();
      e_len   = exp_q.pop_front();
      check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
      check("byte_reads", 64'(idx), e_len);
      if (stall_mode == 0) check("latency", 64'(edges), e_len + 64'd1);
      check_fields("done");
      for (int h = 0; h < hold; h++) begin
         bus.out_ready = 1'b0;
         bus.pc_valid  = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("hold_out_valid", 64'(bus.out_valid), 64'd1);
         check("hold_pc_ready", 64'(bus.pc_ready), 64'd0);
         check("hold_mem_req", 64'(bus.mem_req), 64'd0);
         check_fields("hold");
      end
      bus.out_ready = 1'b1;
      bus.pc_valid  = 1'b0;
      bus.mem_rvalid = 1'b0;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("after_hs_out_valid", 64'(bus.out_valid), 64'd0);
      check("after_hs_pc_ready", 64'(bus.pc_ready), 64'd1);
   endtask

   task automatic load_img(input logic [7:0] b[10]);
      img.delete();
      for (int i = 0; i < 10; i++) img.push_back(b[i]);
   endtask

   task automatic load_random(input logic [7:0] first);
      img.delete();
      img.push_back(first);
      for (int i = 1; i < 10; i++) img.push_back(8'($urandom_range(0, 255)));
   endtask

   initial begin
      logic [7:0]  b[10];
      logic [63:0] pc;
      bus.pc_valid   = 1'b0;
      bus.pc_addr    = '0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 8'h00;
      bus.out_ready  = 1'b0;
      #12;
      check_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // irmovq-style: 30 F3 0A 00.. at 0x100
      b = '{8'h30, 8'hF3, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      load_img(b);
      run_fetch(64'h100, 0, 0, 0);
      check("req034_valP", bus.valP, 64'h10A);

      // jump-style 9-byte: 70 40 00..
      b = '{8'h70, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11};
      load_img(b);
      run_fetch(64'h20, 0, 1, 0);
      check("req035_valC", bus.valC, 64'h40);

      // single byte with 5 cycles of back-pressure
      load_random(8'h10);
      run_fetch(64'h0, 0, 5, 0);

      // 60 21 with three stall cycles before each byte
      load_random(8'h60);
      img[1] = 8'h21;
      run_fetch(64'h4000, 2, 0, 0);

      // reset in the middle of a 10-byte fetch, then a fresh 1-byte fetch
      load_random(8'h30);
      run_fetch(64'h500, 0, 0, 4);
      check_reset("post_reset");
      load_random(8'h90);
      run_fetch(64'h777, 0, 0, 0);

      // undefined icode
      load_random(8'hC0);
      run_fetch(64'h900, 0, 0, 0);

      // address wrap at the top of the space
      load_random(8'h40);
      run_fetch(64'hFFFF_FFFF_FFFF_FFFB, 1, 0, 0);

      for (int n = 0; n < 30; n++) begin
         load_random(8'($urandom_range(0, 255)));
         pc = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15)))
                                          : {$urandom, $urandom};
         run_fetch(pc, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: ADDR_W, 64, width of PC and memory address.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 pc_valid  input  1  pc_addr holds a new instruction address.
REQ-005 pc_addr  input  ADDR_W  start address of the instruction.
REQ-006 pc_ready  output  1  block is idle and accepts pc_addr.
REQ-007 mem_req  output  1  byte read request.
REQ-008 mem_addr  output  ADDR_W  byte address being read.
REQ-009 mem_rvalid  input  1  mem_rdata valid for the current request.
REQ-010 mem_rdata  input  8  returned instruction byte.
REQ-011 out_valid  output  1  decoded instruction fields valid.
REQ-012 out_ready  input  1  consumer accepts decoded fields.
REQ-013 icode, ifun, rA, rB  output  4 each  decoded nibbles.
REQ-014 valC  output  64  constant word, little-endian assembled.
REQ-015 valP  output  ADDR_W  pc_addr + instruction length, modulo 2^ADDR_W.
REQ-016 instr_err  output  1  invalid icode (see Configuration).

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, DONE; pc_ready SHALL be 1 only in IDLE.
REQ-018 IDLE->FETCH SHALL occur on a cycle with pc_valid=1; pc_addr SHALL be latched and the byte index cleared to 0.
REQ-019 In FETCH, mem_req SHALL be 1 and mem_addr SHALL be latched PC + byte index.
REQ-020 A byte SHALL transfer only on a cycle with mem_req=1 and mem_rvalid=1; the index then increments by 1.
REQ-021 mem_rvalid while mem_req=0 SHALL be ignored; indefinite mem_rvalid=0 SHALL hold FETCH with no state change.
REQ-022 Byte 0 SHALL load icode=bits[7:4], ifun=bits[3:0]; the length SHALL be decoded from that byte in the same cycle.
REQ-023 Lengths: icode 0,1,9 -> 1; 2,6,10,11 -> 2; 3,4,5 -> 10; 7,8 -> 9.
REQ-024 For lengths 2 and 10, byte 1 SHALL load rA=bits[7:4], rB=bits[3:0]; for other lengths, rA and rB SHALL be 4'hF.
REQ-025 valC SHALL be bytes 2..9 (length 10) or bytes 1..8 (length 9), byte at lowest address in valC[7:0]; otherwise valC SHALL be 0.
REQ-026 When the final byte transfers, the FSM SHALL go to DONE with out_valid=1 on the next cycle; minimum pc_valid-to-out_valid latency SHALL be length+1 cycles.
REQ-027 In DONE, all outputs SHALL hold stable until out_valid&out_ready; the FSM then returns to IDLE, and a new pc_valid SHALL be accepted no earlier than the following cycle.
REQ-028 pc_valid outside IDLE SHALL be ignored.
REQ-029 Address arithmetic (mem_addr, valP) SHALL wrap modulo 2^ADDR_W.

Reset
REQ-030 rst_n low SHALL force IDLE asynchronously, including mid-FETCH or mid-DONE; the in-flight instruction is discarded.
REQ-031 Reset values: pc_ready=1, mem_req=0, mem_addr=0, out_valid=0, icode=ifun=0, rA=rB=4'hF, valC=0, valP=0, instr_err=0.

Configuration
REQ-032 With INSTR_CHECK_EN defined, icode>11 SHALL end the fetch after byte 0, setting instr_err=1, length=1, rA=rB=4'hF, valC=0.
REQ-033 Without INSTR_CHECK_EN, icode>11 SHALL be treated as length 1 with instr_err tied to 0.

Verification
REQ-034 pc=0x100, bytes 30 F3 0A 00 00 00 00 00 00 00, mem_rvalid always 1 -> icode=3, rA=F, rB=3, valC=0xA, valP=0x10A, out_valid at cycle 11.
REQ-035 pc=0x20, bytes 70 40 00 00 00 00 00 00 00 -> icode=7, valC=0x40, valP=0x29, rA=rB=F.
REQ-036 pc=0, byte 10 with out_ready=0 for 5 cycles -> out_valid and fields held for 5 cycles, pc_ready=0 until after the handshake.
REQ-037 Fetch of 60 21 with mem_rvalid low for 3 cycles before each byte -> mem_addr stable while stalled, icode=6, ifun=0, rA=2, rB=1.
REQ-038 rst_n pulsed low at byte 4 of an irmovq -> immediate IDLE with REQ-031 values; a new fetch of 90 returns icode=9 and valP=pc+1.
REQ-039 INSTR_CHECK_EN defined, byte C0 -> instr_err=1, one memory read, valP=pc+1; undefined -> instr_err=0.
